// File: rtl/count_sequencer_pkg.sv
// Shared state encodings and defaults for the count sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package count_sequencer_pkg;

    localparam int WIDTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/count_sequencer_tff_bit.sv
// Toggle flip-flop holding one bit of the sequencer count.
// Latency: Q flips on the rising edge after T is sampled high.
// Backpressure: none; T is honoured every cycle.
module tff_bit (
    input  logic clk,
    input  logic RSTN,
    input  logic T,
    output logic Q
);

    // Toggle on T, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            Q <= 1'b0;
        end else if (T) begin
            Q <= ~Q;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Start/stop/pause/step counter sequencer running from 0 up to a captured limit.
// Latency: count and state update one edge after inputs; status is decoded from registered state.
// Backpressure: none; start is only accepted in IDLE, stop > pause > step elsewhere.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             step,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_limit_q;
    logic [WIDTH-1:0]   w_count;
    logic [WIDTH-1:0]   w_count_plus1;
    logic [WIDTH-1:0]   w_toggle;
    logic               w_inc;
    logic               w_clr;
    logic               w_capture;

    assign w_count_plus1 = w_count + {{(WIDTH-1){1'b0}}, 1'b1};

    // State register; reset lands in IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Terminal count is frozen at start so later limit changes are ignored.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_limit_q <= '0;
        end else if (w_capture) begin
            r_limit_q <= limit;
        end
    end

    // Next state plus the count controls (increment / clear / capture).
    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_clr       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_clr       = 1'b1;
                    w_state_nxt = (limit == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (pause) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_inc = 1'b1;
                    if (w_count_plus1 == r_limit_q) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (!pause) begin
                    w_state_nxt = ST_RUN;
                end else if (step) begin
                    w_inc = 1'b1;
                    if (w_count_plus1 == r_limit_q) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (AUTO_RELOAD) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Ripple-carry toggle enables; clearing toggles exactly the bits that are set.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign w_toggle[gi] = w_clr ? w_count[gi] : w_inc;
            end else begin : g_upper
                assign w_toggle[gi] = w_clr ? w_count[gi] : (w_inc & (&w_count[gi-1:0]));
            end

            tff_bit u_tff (
                .clk  (clk),
                .RSTN (RSTN),
                .T    (w_toggle[gi]),
                .Q    (w_count[gi])
            );
        end
    endgenerate

    assign count = w_count;
    assign state = r_state;
    assign busy  = (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign done  = (r_state == ST_DONE);

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 3: count/limit width in bits, legal range 2..8.
REQ-002 SHALL have parameter AUTO_RELOAD, default 0: 1 = restart automatically after each completed run.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a run; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1  abort the current run.
REQ-007 SHALL have port pause  input  1  hold the count while high.
REQ-008 SHALL have port step  input  1  single increment while in HOLD.
REQ-009 SHALL have port limit  input  WIDTH  terminal count; captured on start.
REQ-010 SHALL have port count  output  WIDTH  current count value.
REQ-011 SHALL have port busy  output  1  high in RUN or HOLD.
REQ-012 SHALL have port done  output  1  high exactly while state is DONE (one cycle per completed run).
REQ-013 SHALL have port state  output  2  encoded FSM state.

Function
REQ-014 SHALL implement states IDLE=2'b00, RUN=2'b01, HOLD=2'b10, DONE=2'b11.
REQ-015 SHALL use priority stop > pause > step for simultaneous inputs; start SHALL be ignored outside IDLE.
REQ-016 IDLE, start=1: SHALL capture limit into limit_q and set count<=0; next state RUN, or DONE if limit==0.
REQ-017 IDLE, start=0: SHALL hold count and state.
REQ-018 RUN, no stop/pause: SHALL set count<=count+1 each edge; if count+1==limit_q, next state DONE, else RUN.
REQ-019 RUN, pause=1: SHALL go to HOLD without incrementing on that edge.
REQ-020 HOLD, pause=0: SHALL go to RUN without incrementing on that edge.
REQ-021 HOLD, pause=1, step=1: SHALL increment count once per edge with step high and go to DONE if count+1==limit_q.
REQ-022 HOLD, pause=1, step=0: SHALL hold count and stay in HOLD.
REQ-023 stop=1 in RUN/HOLD/DONE: SHALL go to IDLE next edge, hold count, and assert no further done.
REQ-024 DONE: SHALL last one cycle; next state IDLE with count held at limit_q when AUTO_RELOAD=0, or RUN with count<=0 when AUTO_RELOAD=1; pause/step ignored.
REQ-025 limit changes after capture SHALL have no effect until the next start.
REQ-026 count arithmetic SHALL be modulo 2^WIDTH; because limit_q<=2^WIDTH-1, count SHALL never pass limit_q.
REQ-027 busy, done and state SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-028 RSTN low SHALL immediately, without a clock edge, force state=IDLE, count=0, limit_q=0, busy=0, done=0.
REQ-029 Reset asserted mid-run SHALL abort with no done pulse; the first edge after release SHALL evaluate from IDLE.

Structure
REQ-030 Package count_sequencer_pkg SHALL hold the state encodings and the WIDTH default.
REQ-031 The count register SHALL be WIDTH instances of sub-module tff_bit (clk, RSTN, T, Q).
REQ-032 Bit i toggle SHALL be inc & AND(Q[i-1:0]); synchronous clear SHALL be T=Q.

Verification
REQ-033 Reset, then start with limit=5 -> count 0,1,2,3,4,5 on successive edges; busy high 5 cycles; done high exactly 1 cycle; then IDLE with count=5.
REQ-034 Start with limit=0 -> DONE on the next edge; done pulses once; count=0; busy never high.
REQ-035 limit=5, pause at count=2 for 4 cycles with step high on 2 of them -> count=4 in HOLD; pause released -> count=5, DONE.
REQ-036 limit=6, stop at count=3 -> IDLE, count=3, no done; start again -> count restarts at 0.
REQ-037 AUTO_RELOAD=1, WIDTH=3, limit=7 -> count 0..7 repeating; done pulses every 8 cycles.
REQ-038 RSTN low asynchronously at count=4 in RUN -> count=0, state=IDLE, busy=0 before the next clk edge.
